// File: rtl/posit_defines_pipe_pkg.sv
// posit_defines_pipe: shared width helpers for the pipelined raw-posit multiplier.
//
// Contents:
//   in_w   - serialized operand width  {sgn, scale, fraction, inf, zero}
//   mbits  - full significand product width (hidden bits included)
//   ps_w   - product scale width (one guard bit so the scale sum never wraps)
//   pfrac_w- product fraction width carried on the output bus
//   out_w  - serialized product width {sgn, scale, fraction, inf, zero}
//
// Build option: POSITMULT_STICKY_EN narrows the product fraction to FBITS+3
// bits (FBITS+2 significant bits plus one sticky bit).
//
// The value / value_product struct typedefs and their serialize/deserialize
// functions depend on module parameters, so they live in the top module where
// the widths are known; this package provides the widths they are built from.
package posit_defines_pipe;

  function automatic int in_w(input int sbits, input int fbits);
    return sbits + fbits + 3;
  endfunction

  function automatic int mbits(input int fbits);
    return 2 * (fbits + 1);
  endfunction

  function automatic int ps_w(input int sbits);
    return sbits + 1;
  endfunction

  function automatic int pfrac_w(input int fbits);
`ifdef POSITMULT_STICKY_EN
    return fbits + 3;
`else
    return mbits(fbits);
`endif
  endfunction

  function automatic int out_w(input int sbits, input int fbits);
    return ps_w(sbits) + pfrac_w(fbits) + 3;
  endfunction

endpackage

// File: rtl/posit_pipe_stage.sv
// posit_pipe_stage: one register slice of the multiplier pipeline.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset (clears everything)
//   en              - load enable; low holds data, tag and valid (global stall)
//   d_data/d_tag/d_valid - incoming payload, sideband tag and valid bit
//   q_data/q_tag/q_valid - registered payload, tag and valid bit
//
// Bubbles are loaded like any other slot, so the pipeline never compacts.
module posit_pipe_stage #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d_data,
  input  logic [TAG_W-1:0]  d_tag,
  input  logic              d_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [TAG_W-1:0]  q_tag,
  output logic              q_valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_data  <= '0;
      q_tag   <= '0;
      q_valid <= 1'b0;
    end else if (en) begin
      q_data  <= d_data;
      q_tag   <= d_tag;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/positmult_raw_pipe.sv
// positmult_raw_pipe: pipelined multiplier for serialized raw posits.
//
// Operands are {sgn, scale[SBITS], fraction[FBITS], inf, zero}, MSB first.
// The product is {sgn, scale[SBITS+1], fraction, inf, zero}, unrounded, with
// canonical specials (inf clears every other field, zero clears sgn/scale/frac).
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in1, in2, in_tag      - operands and sideband tag
//   in_valid / in_ready   - input handshake
//   result, out_tag       - product and its tag
//   out_valid / out_ready - output handshake
//
// Pipeline: stage 0 registers the operands, stage 1 registers the product,
// stages 2..LATENCY-1 are plain delay. A single global enable stalls every
// stage whenever the output holds a result the consumer has not taken.
//
// Build option: POSITMULT_STICKY_EN compacts the product fraction to FBITS+3
// bits (top FBITS+2 bits plus a sticky OR of the rest).
module positmult_raw_pipe
  import posit_defines_pipe::*;
#(
  parameter int SBITS   = 9,
  parameter int FBITS   = 26,
  parameter int LATENCY = 4,
  parameter int TAG_W   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [in_w(SBITS, FBITS)-1:0]     in1,
  input  logic [in_w(SBITS, FBITS)-1:0]     in2,
  input  logic [TAG_W-1:0]                  in_tag,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [out_w(SBITS, FBITS)-1:0]    result,
  output logic [TAG_W-1:0]                  out_tag,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int IN_W  = in_w(SBITS, FBITS);
  localparam int MBITS = mbits(FBITS);
  localparam int PS_W  = ps_w(SBITS);
  localparam int PF_W  = pfrac_w(FBITS);
  localparam int OUT_W = out_w(SBITS, FBITS);

  typedef struct packed {
    logic                    sgn;
    logic [SBITS-1:0]        scale;
    logic [FBITS-1:0]        frac;
    logic                    inf;
    logic                    zero;
  } value_t;

  typedef struct packed {
    logic                    sgn;
    logic [PS_W-1:0]         scale;
    logic [PF_W-1:0]         frac;
    logic                    inf;
    logic                    zero;
  } value_product_t;

  function automatic value_t deserialize(input logic [IN_W-1:0] v);
    return value_t'(v);
  endfunction

  function automatic logic [OUT_W-1:0] serialize(input value_product_t p);
    return OUT_W'(p);
  endfunction

  // A zero operand carries no meaningful payload; clear it so stray bits
  // never leak into the sign or the inf flag of the product.
  function automatic value_t canon_in(input value_t v);
    value_t r;
    r = v;
    if (v.zero) begin
      r.sgn   = 1'b0;
      r.scale = '0;
      r.frac  = '0;
      r.inf   = 1'b0;
    end
    return r;
  endfunction

  logic                 advance;
  logic [2*IN_W-1:0]    s0_d;
  logic [2*IN_W-1:0]    s0_q;
  logic [OUT_W-1:0]     mult_out;
  logic [OUT_W-1:0]     pay_q [1:LATENCY-1];
  logic [TAG_W-1:0]     tag_q [LATENCY];
  logic                 vld_q [LATENCY];

  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;
  assign s0_d     = {canon_in(deserialize(in1)), canon_in(deserialize(in2))};

  // Multiply stage datapath.
  value_t            op_a;
  value_t            op_b;
  logic [MBITS-1:0]  mult;
  logic [MBITS-1:0]  frac_full;
  value_product_t    prod;

  always_comb begin
    op_a = value_t'(s0_q[2*IN_W-1:IN_W]);
    op_b = value_t'(s0_q[IN_W-1:0]);
    mult = {{(MBITS-FBITS-1){1'b0}}, 1'b1, op_a.frac} *
           {{(MBITS-FBITS-1){1'b0}}, 1'b1, op_b.frac};

    // Product of two [1,2) significands lies in [1,4): the top bit says
    // whether it reached 2, which bumps the scale and needs one less shift
    // to drop the hidden bit.
    frac_full = mult[MBITS-1] ? {mult[MBITS-2:0], 1'b0} : {mult[MBITS-3:0], 2'b00};

    prod       = '0;
    prod.sgn   = op_a.sgn ^ op_b.sgn;
    prod.scale = {op_a.scale[SBITS-1], op_a.scale} + {op_b.scale[SBITS-1], op_b.scale}
               + {{(PS_W-1){1'b0}}, mult[MBITS-1]};
`ifdef POSITMULT_STICKY_EN
    prod.frac  = {frac_full[MBITS-1 -: FBITS+2], |frac_full[FBITS-1:0]};
`else
    prod.frac  = frac_full;
`endif
    prod.inf   = op_a.inf | op_b.inf;
    prod.zero  = ~prod.inf & (op_a.zero | op_b.zero);

    if (prod.inf) begin
      prod.sgn   = 1'b0;
      prod.scale = '0;
      prod.frac  = '0;
    end else if (prod.zero) begin
      prod.sgn   = 1'b0;
      prod.scale = '0;
      prod.frac  = '0;
    end
    mult_out = serialize(prod);
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_in
        posit_pipe_stage #(.DATA_W(2*IN_W), .TAG_W(TAG_W)) u_stage (
          .clk     (clk),
          .reset   (reset),
          .en      (advance),
          .d_data  (s0_d),
          .d_tag   (in_tag),
          .d_valid (in_valid),
          .q_data  (s0_q),
          .q_tag   (tag_q[0]),
          .q_valid (vld_q[0])
        );
      end else if (gi == 1) begin : g_mul
        posit_pipe_stage #(.DATA_W(OUT_W), .TAG_W(TAG_W)) u_stage (
          .clk     (clk),
          .reset   (reset),
          .en      (advance),
          .d_data  (mult_out),
          .d_tag   (tag_q[0]),
          .d_valid (vld_q[0]),
          .q_data  (pay_q[1]),
          .q_tag   (tag_q[1]),
          .q_valid (vld_q[1])
        );
      end else begin : g_dly
        posit_pipe_stage #(.DATA_W(OUT_W), .TAG_W(TAG_W)) u_stage (
          .clk     (clk),
          .reset   (reset),
          .en      (advance),
          .d_data  (pay_q[gi-1]),
          .d_tag   (tag_q[gi-1]),
          .d_valid (vld_q[gi-1]),
          .q_data  (pay_q[gi]),
          .q_tag   (tag_q[gi]),
          .q_valid (vld_q[gi])
        );
      end
    end
  endgenerate

  assign result    = pay_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];
  assign out_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_positmult_raw_pipe.sv
// Testbench for positmult_raw_pipe at default parameters (SBITS=9, FBITS=26,
// LATENCY=4, TAG_W=8), default build.
module tb_positmult_raw_pipe;

  localparam int SBITS = 9;
  localparam int FBITS = 26;
  localparam int LAT   = 4;
  localparam int TAG_W = 8;
  localparam int IN_W  = SBITS + FBITS + 3;
  localparam int MBITS = 2 * (FBITS + 1);
  localparam int OUT_W = (SBITS + 1) + MBITS + 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [IN_W-1:0]   in1, in2;
  logic [TAG_W-1:0]  in_tag;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_valid;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  positmult_raw_pipe #(.SBITS(SBITS), .FBITS(FBITS), .LATENCY(LAT), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in1       (in1),
    .in2       (in2),
    .in_tag    (in_tag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_tag   (out_tag),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [IN_W-1:0] mk_in(input logic sgn, input int scale,
                                            input logic [FBITS-1:0] frac,
                                            input logic inf, input logic zero);
    logic [SBITS-1:0] s;
    s = scale[SBITS-1:0];
    return {sgn, s, frac, inf, zero};
  endfunction

  function automatic logic [OUT_W-1:0] mk_out(input logic sgn, input int scale,
                                              input logic [MBITS-1:0] frac,
                                              input logic inf, input logic zero);
    logic [SBITS:0] s;
    s = scale[SBITS:0];
    return {sgn, s, frac, inf, zero};
  endfunction

  task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  typedef struct {
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic [OUT_W-1:0] exp;
    string            name;
  } vec_t;

  vec_t vecs[11];

  // Single op through an idle pipe: checks latency, result and tag.
  task automatic run_one(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                         input logic [TAG_W-1:0] tg, input logic [OUT_W-1:0] ex,
                         input string nm);
    int n;
    @(negedge clk);
    in1 = a; in2 = b; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({nm, " latency"}, OUT_W'(n), OUT_W'(LAT));
    chk({nm, " result"}, result, ex);
    chk({nm, " tag"}, OUT_W'(out_tag), OUT_W'(tg));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] one;
    int sent, rcvd, nstall;
    logic prev_stall, stall;
    logic [OUT_W-1:0] held_r;
    logic [TAG_W-1:0] held_t;

    one = mk_in(1'b0, 0, '0, 1'b0, 1'b0);
    vecs[0]  = '{one, one, mk_out(0, 0, '0, 0, 0), "1.0x1.0"};
    vecs[1]  = '{mk_in(0, 0, 26'd1 << 25, 0, 0), mk_in(1, 0, 26'd1 << 25, 0, 0),
                 mk_out(1, 1, 54'd1 << 51, 0, 0), "1.5x-1.5"};
    vecs[2]  = '{mk_in(0, -3, '0, 0, 0), mk_in(0, 5, '0, 0, 0), mk_out(0, 2, '0, 0, 0), "sc-3xsc5"};
    vecs[3]  = '{mk_in(0, 255, '0, 0, 0), mk_in(0, 255, '0, 0, 0), mk_out(0, 510, '0, 0, 0), "sc255x255"};
    vecs[4]  = '{mk_in(0, -256, '0, 0, 0), mk_in(0, -256, '0, 0, 0), mk_out(0, -512, '0, 0, 0), "sc-256x-256"};
    vecs[5]  = '{mk_in(0, 0, '0, 0, 1), mk_in(0, 0, '0, 1, 0), mk_out(0, 0, '0, 1, 0), "zeroxinf"};
    vecs[6]  = '{mk_in(0, 0, '0, 0, 1), one, mk_out(0, 0, '0, 0, 1), "zerox1.0"};
    vecs[7]  = '{mk_in(1, 7, 26'd123, 1, 1), mk_in(1, 3, '0, 0, 0), mk_out(0, 0, '0, 0, 1), "dirtyzerox-1"};
    vecs[8]  = '{mk_in(0, 0, 26'd3 << 24, 0, 0), mk_in(0, 0, 26'd3 << 24, 0, 0),
                 mk_out(0, 1, (54'd1 << 53) | (54'd1 << 49), 0, 0), "1.75x1.75"};
    vecs[9]  = '{mk_in(0, 2, 26'd1 << 24, 0, 0), mk_in(1, -1, 26'd1 << 24, 0, 0),
                 mk_out(1, 1, (54'd1 << 53) | (54'd1 << 50), 0, 0), "1.25s2x-1.25s-1"};
    vecs[10] = '{mk_in(1, 4, '0, 1, 0), mk_in(1, -4, 26'd5, 1, 0), mk_out(0, 0, '0, 1, 0), "infxinf"};

    // Reset state
    reset = 1'b1; in1 = '0; in2 = '0; in_tag = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", OUT_W'(out_valid), '0);
    chk("reset result", result, '0);
    chk("reset out_tag", OUT_W'(out_tag), '0);
    chk("reset in_ready", OUT_W'(in_ready), OUT_W'(1));
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 11; i++)
      run_one(vecs[i].a, vecs[i].b, TAG_W'(8'h40 + i), vecs[i].exp, vecs[i].name);

    // Stream 6 tagged ops with a 5-cycle output stall in the middle
    sent = 0; rcvd = 0; nstall = 0; prev_stall = 1'b0;
    held_r = '0; held_t = '0;
    for (int cyc = 0; cyc < 60 && rcvd < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 11);
      if (sent < 6) begin
        in1 = mk_in(0, sent + 1, '0, 0, 0);
        in2 = mk_in(0, 1, '0, 0, 0);
        in_tag = TAG_W'(sent + 1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk("stall hold valid", OUT_W'(out_valid), OUT_W'(1));
        chk("stall hold result", result, held_r);
        chk("stall hold tag", OUT_W'(out_tag), OUT_W'(held_t));
      end
      stall = out_valid & ~out_ready;
      if (stall) begin
        nstall++;
        chk("stall in_ready", OUT_W'(in_ready), '0);
        held_r = result;
        held_t = out_tag;
      end
      if (out_valid && out_ready) begin
        chk("stream tag", OUT_W'(out_tag), OUT_W'(rcvd + 1));
        chk("stream result", result, mk_out(0, rcvd + 2, '0, 0, 0));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = stall;
    end
    chk("stream received", OUT_W'(rcvd), OUT_W'(6));
    chk("stream stall seen", OUT_W'(nstall > 0), OUT_W'(1));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stream no duplicate", OUT_W'(out_valid), '0);
    end

    // Reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in1 = one; in2 = one; in_tag = TAG_W'(8'h90 + k); in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset out_valid", OUT_W'(out_valid), '0);
    chk("midreset result", result, '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midreset no stale", OUT_W'(out_valid), '0);
    end
    run_one(mk_in(0, 0, 26'd1 << 25, 0, 0), mk_in(1, 0, 26'd1 << 25, 0, 0),
            8'hA5, mk_out(1, 1, 54'd1 << 51, 0, 0), "postreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
